// File: rtl/tx_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_pkg : shared widths, FSM encoding and line levels for frame_transmitter
// Rev 1.0
// ---------------------------------------------------------------------------
package tx_pkg;

  localparam int DATA_W = 8;
  localparam logic START_LEVEL = 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_fifo : power-of-two byte FIFO; a push is refused whenever it is full
// Rev 1.0
// ---------------------------------------------------------------------------
module tx_fifo
  import tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot
  assign full   = (r_count == C_FULL);
  assign w_push = push && !full;
  assign w_pop  = pop && (r_count != '0);
  assign rdata  = r_mem[r_rd];
  assign count  = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_transmitter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_transmitter : queued byte framer, start bit + 8 data LSB first + gap
// Rev 1.0
// ---------------------------------------------------------------------------
module frame_transmitter
  import tx_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              send,
  output logic              ready,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] C_GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [1:0]            r_state;
  logic [DATA_W-1:0]     r_shift;
  logic [2:0]            r_bit;
  logic [GW-1:0]         r_gap;
  logic                  r_txd;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_full;
  logic [$clog2(DEPTH):0] w_count;
  logic [DATA_W-1:0]     w_head;
  logic                  w_avail;
  logic                  w_gap_last;
  logic                  w_pop;

  assign ready      = !w_full;
  assign w_avail    = (w_count != '0);
  assign w_gap_last = (r_state == ST_GAP) && (r_gap == C_GAP_LAST);
  assign w_pop      = w_avail && ((r_state == ST_IDLE) || w_gap_last);

  tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (send),
    .pop   (w_pop),
    .wdata (data_in),
    .rdata (w_head),
    .full  (w_full),
    .count (w_count)
  );

  // Outputs are registered from the current state, so the line trails the FSM by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_gap   <= '0;
      r_txd   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_txd  <= 1'b0;
      r_busy <= (r_state != ST_IDLE);
      r_done <= (r_state == ST_GAP) && (r_gap == '0);
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_shift <= w_head;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_txd   <= START_LEVEL;
          r_bit   <= '0;
          r_state <= ST_DATA;
        end
        ST_DATA: begin
          r_txd   <= r_shift[0];
          r_shift <= r_shift >> 1;
          r_bit   <= r_bit + 1'b1;
          if (r_bit == 3'd7) begin
            r_gap   <= '0;
            r_state <= ST_GAP;
          end
        end
        default: begin
          if (w_gap_last) begin
            r_gap <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
      endcase
    end
  end

  assign txd  = r_txd;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_frame_transmitter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_frame_transmitter : directed + random stimulus against a frame-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_frame_transmitter;

  localparam int DEPTH = 4;
  localparam int G     = 2;
  localparam int FRAME = 9 + G;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready, txd, busy, done;

  frame_transmitter #(.DEPTH(DEPTH), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .send(send),
    .ready(ready), .txd(txd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: byte queue plus position within the current frame (-1 = line idle)
  logic [7:0] q[$];
  int         ph = -1;
  logic [7:0] cur = 8'h00;
  logic       e_txd = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  logic       armed = 1'b0;
  int         cyc_no = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic [7:0] d);
    logic pop, acc;
    rst = r; send = s; data_in = d;
    #1;
    if (armed) chk("ready", {15'd0, ready}, {15'd0, (q.size() < DEPTH)});
    if (r) begin
      q.delete(); ph = -1; cur = 8'h00;
      e_txd = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      e_txd  = (ph == 0) ? 1'b1 : ((ph >= 1 && ph <= 8) ? cur[ph-1] : 1'b0);
      e_busy = (ph >= 0);
      e_done = (ph == 9);
      acc = s && (q.size() < DEPTH);
      pop = (q.size() > 0) && (ph == -1 || ph == FRAME - 1);
      if (pop) begin
        cur = q.pop_front();
        ph  = 0;
      end else if (ph == FRAME - 1) ph = -1;
      else if (ph >= 0) ph++;
      if (acc) q.push_back(d);
    end
    @(posedge clk);
    #1;
    cyc_no++;
    if (armed) begin
      chk("txd",  {15'd0, txd},  {15'd0, e_txd});
      chk("busy", {15'd0, busy}, {15'd0, e_busy});
      chk("done", {15'd0, done}, {15'd0, e_done});
    end
  endtask

  initial begin : main
    logic [10:0] pat;
    int nd, last_done, guard;
    #1;
    cyc(1'b1, 1'b0, 8'h00);
    armed = 1'b1;
    cyc(1'b1, 1'b1, 8'hEE);

    // single 0xA5 frame
    cyc(1'b0, 1'b1, 8'hA5);
    cyc(1'b0, 1'b0, 8'h00);
    pat = '0; nd = 0;
    for (int i = 0; i < 11; i++) begin
      cyc(1'b0, 1'b0, 8'h00);
      pat = {pat[9:0], txd};
      if (done) nd++;
    end
    chk("a5_seq",   {5'd0, pat}, {5'd0, 11'b110_1001_0100});
    chk("a5_dones", 16'(nd), 16'd1);
    cyc(1'b0, 1'b0, 8'h00);
    chk("a5_busy_low", {15'd0, busy}, 16'd0);

    // burst of three, back to back
    cyc(1'b0, 1'b1, 8'h01);
    cyc(1'b0, 1'b1, 8'h80);
    cyc(1'b0, 1'b1, 8'hFF);
    nd = 0; last_done = -1;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 1'b0, 8'h00);
      if (done) begin
        if (last_done >= 0) chk("burst_spacing", 16'(cyc_no - last_done), 16'(FRAME));
        last_done = cyc_no;
        nd++;
      end
    end
    chk("burst_dones", 16'(nd), 16'd3);

    // fill the FIFO while a frame is on the line
    cyc(1'b0, 1'b1, 8'h11);
    cyc(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h22 * (i + 1)));
    chk("full_ready", {15'd0, ready}, 16'd0);
    for (int i = 0; i < 60; i++) cyc(1'b0, 1'b0, 8'h00);

    // reset during D3 of 0x3C with two bytes queued
    cyc(1'b0, 1'b1, 8'h3C);
    cyc(1'b0, 1'b1, 8'h5A);
    cyc(1'b0, 1'b1, 8'h77);
    guard = 0;
    while (ph != 4 && guard < 30) begin
      cyc(1'b0, 1'b0, 8'h00);
      guard++;
    end
    chk("reach_d3", 16'(ph), 16'd4);
    cyc(1'b1, 1'b1, 8'h99);
    chk("rst_ready", {15'd0, ready}, 16'd1);
    nd = 0; pat = '0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 8'h00);
      if (done) nd++;
      if (txd) pat[0] = 1'b1;
    end
    chk("rst_no_done", 16'(nd), 16'd0);
    chk("rst_line_low", {15'd0, pat[0]}, 16'd0);

    // random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
    end
    for (int i = 0; i < 80; i++) cyc(1'b0, 1'b0, 8'h00);
    chk("drained", 16'(q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
